mmu_task: RTL and testbench
===========================

Name: mmu_task

Overview:
- Parametrised successor to the SBC09 MMU core for the 6809 CPU.
- Translates 16-bit logical addresses into physical page numbers.
- Holds the page tables on-chip in registers, with NUM_TASKS selectable task contexts and per-page write protection.
- Switches automatically to the system task on an interrupt vector fetch, and returns to the user task after a delayed "go".
- Sits between the CPU bus and the memory/device select decode; its PPN output drives the upper physical address lines.

Parameters:
NUM_TASKS, 4, number of task contexts; power of 2, 2..16; task 0 is the system task
PAGE_BITS, 13, log2 page size; 12..15, giving NPAGES = 2^(16-PAGE_BITS) = 2..16
PPN_BITS, 7, physical page number width; 1..7
MMU_BASE, 16'hFE20, base of the 16-byte register window

Ports:
E  in  1  CPU E clock; the only clock; all state updates on the rising edge
RESET  in  1  synchronous reset, active-high
ADDR  in  16  CPU logical address
RnW  in  1  1 = read, 0 = write
BA  in  1  6809 bus available
BS  in  1  6809 bus status; BA=0 with BS=1 is a vector fetch
DATA_in  in  8  CPU write data
DATA_out  out  8  register read data
DATA_oe  out  1  drive DATA; equals MMU_SEL & RnW
MMU_SEL  out  1  ADDR in MMU_BASE..MMU_BASE+15
PPN  out  PPN_BITS  translated physical page number
ACTIVE_TASK  out  4  current task; upper bits 0
WR_INHIBIT  out  1  suppress memory write for this cycle
FAULT  out  1  latched protection fault; level interrupt request

Behaviour:
- Register map (ADDR[3:0]); writes take effect on the E edge ending the cycle with MMU_SEL=1 and RnW=0:
  - 0 CTRL: b0 EN, b1 PROT_EN, b7 FAULT. Read returns all three. A write sets b0/b1; writing b7=1 clears FAULT.
  - 1 ACCTASK: task whose table appears at 8..15. Masked to log2(NUM_TASKS) bits.
  - 2 USERTASK: masked the same way.
  - 3 GO: write n → PEND=1, CNT=n.
    - Each later edge with PEND=1 and CNT≠0 decrements CNT.
    - The edge with PEND=1 and CNT=0 sets ACTIVE_TASK=USERTASK and PEND=0. With n=0 that is the next edge.
    - A write to GO while pending reloads CNT.
    - Read returns CNT.
  - 4/5 FLTADR: hi/lo bytes of the latched fault address; read-only.
  - 8+i ENTRY[ACCTASK][i], i < NPAGES: b7 WP, b[PPN_BITS-1:0] PPN. Other bits read 0. Slots ≥ NPAGES read 0 and ignore writes.
  - 6, 7: read 0.
- Translation (combinational), page index = ADDR[15:PAGE_BITS]:
  - EN=0: PPN = page index zero-extended or truncated to PPN_BITS.
  - EN=1: PPN = ENTRY[ACTIVE_TASK][page].PPN.
  - MMU_SEL accesses are still translated; the downstream decode gives them priority.
- Protection:
  - WR_INHIBIT = EN & PROT_EN & ~RnW & ~MMU_SEL & ACTIVE_TASK≠0 & ENTRY[ACTIVE_TASK][page].WP.
  - On an edge with WR_INHIBIT=1 and FAULT=0: FAULT←1, FLTADR←ADDR.
  - While FAULT=1, further faults are still inhibited but do not overwrite FLTADR.
  - A clear and a new fault on the same edge: the fault wins.
- Vector fetch (BA=0, BS=1) on an edge: ACTIVE_TASK←0 and PEND←0, overriding a GO expiring on that same edge.
- Reset (synchronous):
  - CTRL=0, FAULT=0, ACCTASK=0, USERTASK=0, ACTIVE_TASK=0, PEND=0, CNT=0, FLTADR=0.
  - Every ENTRY[t][i] = {WP=0, PPN=i}, i.e. identity mapping.
  - Outputs after reset: DATA_oe=MMU_SEL&RnW, WR_INHIBIT=0, FAULT=0.
  - Reset mid-countdown abandons the pending switch.
- Simultaneous CPU write to ENTRY and translation of the same page: translation uses the old value this cycle, the new value from the next cycle.

Test Plan:
- Reset, EN=0: ADDR=16'hA000 → PPN=5, WR_INHIBIT=0; read FE28 → 8'h00; read FE2D → 8'h05.
- ACCTASK=1, FE2A←8'h42, USERTASK=1, CTRL←1, GO←2: ACTIVE_TASK stays 0 for two more edges and becomes 1 on the third. Then ADDR=16'h4000 → PPN=8'h42.
- With task 1 active, assert BA=0/BS=1 on the edge that GO would expire → ACTIVE_TASK=0, PEND=0. Read FE23 → 0.
- Task 1, FE2A←8'hC2, CTRL←3, write to 16'h4123 → WR_INHIBIT=1, FAULT=1, FLTADR=16'h4123. A second fault at 16'h5000 leaves FLTADR=16'h4123. Write CTRL←8'h83 → FAULT=0.
- Same write as the previous scenario with ACTIVE_TASK=0 → WR_INHIBIT=0, FAULT stays 0.
- RESET asserted mid-countdown (CNT=5) → next cycle ACTIVE_TASK=0, CNT=0, FE2A reads 8'h02.

Source files
------------

// File: rtl/mmu_task_if.sv
// -----------------------------------------------------------------------------
// mmu_task_if
// CPU-side bus between the 6809 and the mmu_task page translator.
//
//   ADDR        CPU logical address (16)
//   RnW         1 = read, 0 = write
//   BA, BS      6809 bus available / bus status (BA=0,BS=1 is a vector fetch)
//   DATA_in     CPU write data (8)
//   DATA_out    MMU register read data (8)
//   DATA_oe     MMU drives the data bus
//   MMU_SEL     address hits the 16-byte MMU register window
//   PPN         translated physical page number (PPN_BITS)
//   ACTIVE_TASK current task context (4, upper bits zero)
//   WR_INHIBIT  suppress the memory write of this cycle
//   FAULT       latched protection fault, level interrupt request
//
// master: CPU / bench side.  slave: the MMU.
// -----------------------------------------------------------------------------
interface mmu_task_if #(
   parameter int PPN_BITS = 7
);
   logic [15:0]         ADDR;
   logic                RnW;
   logic                BA;
   logic                BS;
   logic [7:0]          DATA_in;
   logic [7:0]          DATA_out;
   logic                DATA_oe;
   logic                MMU_SEL;
   logic [PPN_BITS-1:0] PPN;
   logic [3:0]          ACTIVE_TASK;
   logic                WR_INHIBIT;
   logic                FAULT;

   modport master (
      output ADDR, RnW, BA, BS, DATA_in,
      input  DATA_out, DATA_oe, MMU_SEL, PPN, ACTIVE_TASK, WR_INHIBIT, FAULT
   );

   modport slave (
      input  ADDR, RnW, BA, BS, DATA_in,
      output DATA_out, DATA_oe, MMU_SEL, PPN, ACTIVE_TASK, WR_INHIBIT, FAULT
   );
endinterface

// File: rtl/mmu_task.sv
// -----------------------------------------------------------------------------
// mmu_task
// Page-based MMU for a 6809 system. Maps the 16-bit logical address onto a
// physical page number using on-chip page tables, one per task context, with
// per-page write protection. A vector fetch forces the system task (0); a
// delayed GO returns to the user task.
//
// Ports
//   E      CPU E clock, every state update on its rising edge
//   RESET  synchronous reset, active-high
//   bus    mmu_task_if.slave (CPU address/data/status in, translation out)
//
// Register window at MMU_BASE (offset = ADDR - MMU_BASE):
//   0 CTRL     b0 EN, b1 PROT_EN, b7 FAULT (write 1 to b7 clears FAULT)
//   1 ACCTASK  task whose table is visible at offsets 8..15
//   2 USERTASK task entered when a GO countdown expires
//   3 GO       write n: switch to USERTASK n+1 edges later; read: count left
//   4/5        latched fault address hi/lo (read-only)
//   8+i        ENTRY[ACCTASK][i]: b7 WP, b[PPN_BITS-1:0] PPN
// -----------------------------------------------------------------------------
module mmu_task #(
   parameter int          NUM_TASKS = 4,
   parameter int          PAGE_BITS = 13,
   parameter int          PPN_BITS  = 7,
   parameter logic [15:0] MMU_BASE  = 16'hFE20
) (
   input  logic     E,
   input  logic     RESET,
   mmu_task_if.slave bus
);

   localparam int PG_BITS   = 16 - PAGE_BITS;
   localparam int NPAGES    = 2 ** PG_BITS;
   localparam int TASK_BITS = $clog2(NUM_TASKS);

   typedef enum logic {
      GO_IDLE,
      GO_PEND
   } go_state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic                 r_en;
   logic                 r_prot_en;
   logic                 r_fault;
   logic [TASK_BITS-1:0] r_acc_task;
   logic [TASK_BITS-1:0] r_user_task;
   logic [TASK_BITS-1:0] r_active_task;
   logic [15:0]          r_flt_adr;
   go_state_t            r_go_state;
   logic [7:0]           r_cnt;
   logic                 r_wp  [NUM_TASKS][NPAGES];
   logic [PPN_BITS-1:0]  r_ppn [NUM_TASKS][NPAGES];

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   logic                 w_mmu_sel;
   logic [3:0]           w_reg_idx;
   logic                 w_wr;
   logic                 w_vec_fetch;
   logic [PG_BITS-1:0]   w_page;
   logic [15:0]          w_page_ext;
   logic [PG_BITS-1:0]   w_slot;
   logic                 w_slot_ok;

   // 17-bit compare so a window near the top of the map cannot wrap.
   assign w_mmu_sel   = (bus.ADDR >= MMU_BASE) &&
                        ({1'b0, bus.ADDR} <= ({1'b0, MMU_BASE} + 17'd15));
   assign w_reg_idx   = 4'(bus.ADDR - MMU_BASE);
   assign w_wr        = w_mmu_sel & ~bus.RnW;
   assign w_vec_fetch = ~bus.BA & bus.BS;

   assign w_page      = bus.ADDR[15:PAGE_BITS];
   assign w_page_ext  = {{PAGE_BITS{1'b0}}, w_page};

   // The window only has 8 entry slots; slots beyond NPAGES do not exist.
   assign w_slot      = PG_BITS'(w_reg_idx[2:0]);
   assign w_slot_ok   = w_reg_idx[3] && (32'(w_reg_idx[2:0]) < NPAGES);

   // ---------------------------------------------------------------------------
   // Translation and protection
   // ---------------------------------------------------------------------------
   logic w_wr_inhibit;

   assign bus.PPN = r_en ? r_ppn[r_active_task][w_page]
                         : w_page_ext[PPN_BITS-1:0];

   assign w_wr_inhibit = r_en & r_prot_en & ~bus.RnW & ~w_mmu_sel &
                         (r_active_task != '0) &
                         r_wp[r_active_task][w_page];

   assign bus.WR_INHIBIT  = w_wr_inhibit;
   assign bus.FAULT       = r_fault;
   assign bus.MMU_SEL     = w_mmu_sel;
   assign bus.DATA_oe     = w_mmu_sel & bus.RnW;
   assign bus.ACTIVE_TASK = 4'(r_active_task);

   // ---------------------------------------------------------------------------
   // GO countdown: next-state logic
   // ---------------------------------------------------------------------------
   go_state_t  w_go_next;
   logic [7:0] w_cnt_next;
   logic       w_go_expire;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first;
      // a path that leaves one unassigned would infer a latch.
      w_go_next   = r_go_state;
      w_cnt_next  = r_cnt;
      w_go_expire = 1'b0;

      if (w_wr && (w_reg_idx == 4'd3)) begin
         // A write while already pending simply reloads the count.
         w_go_next  = GO_PEND;
         w_cnt_next = bus.DATA_in;
      end else if (r_go_state == GO_PEND) begin
         if (r_cnt != 8'd0) begin
            w_cnt_next = r_cnt - 8'd1;
         end else begin
            w_go_expire = 1'b1;
            w_go_next   = GO_IDLE;
         end
      end

      // An interrupt vector fetch cancels any pending return to user mode,
      // including one that would have expired on this very edge.
      if (w_vec_fetch) begin
         w_go_next   = GO_IDLE;
         w_go_expire = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // GO countdown: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge E) begin
      // NOTE: sequential state is always updated with non-blocking assignments
      // so every register samples pre-edge values regardless of block order.
      if (RESET) begin
         r_go_state <= GO_IDLE;
         r_cnt      <= 8'd0;
      end else begin
         r_go_state <= w_go_next;
         r_cnt      <= w_cnt_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Control, task and fault registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge E) begin
      if (RESET) begin
         r_en          <= 1'b0;
         r_prot_en     <= 1'b0;
         r_fault       <= 1'b0;
         r_acc_task    <= '0;
         r_user_task   <= '0;
         r_active_task <= '0;
         r_flt_adr     <= 16'd0;
      end else begin
         if (w_wr && (w_reg_idx == 4'd0)) begin
            r_en      <= bus.DATA_in[0];
            r_prot_en <= bus.DATA_in[1];
         end
         if (w_wr && (w_reg_idx == 4'd1)) begin
            r_acc_task <= bus.DATA_in[TASK_BITS-1:0];
         end
         if (w_wr && (w_reg_idx == 4'd2)) begin
            r_user_task <= bus.DATA_in[TASK_BITS-1:0];
         end

         // Only the first fault records its address; a new fault always wins
         // over a clear on the same edge.
         if (w_wr_inhibit) begin
            r_fault <= 1'b1;
            if (!r_fault) begin
               r_flt_adr <= bus.ADDR;
            end
         end else if (w_wr && (w_reg_idx == 4'd0) && bus.DATA_in[7]) begin
            r_fault <= 1'b0;
         end

         if (w_vec_fetch) begin
            r_active_task <= '0;
         end else if (w_go_expire) begin
            r_active_task <= r_user_task;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Page tables
   // ---------------------------------------------------------------------------
   always_ff @(posedge E) begin
      if (RESET) begin
         // NOTE: this register array is reset on purpose: every task must come
         // out of reset with a usable identity map, so the table cannot be
         // left to power-up contents like an ordinary RAM.
         for (int t = 0; t < NUM_TASKS; t++) begin
            for (int i = 0; i < NPAGES; i++) begin
               r_wp[t][i]  <= 1'b0;
               r_ppn[t][i] <= PPN_BITS'(i);
            end
         end
      end else if (w_wr && w_slot_ok) begin
         r_wp[r_acc_task][w_slot]  <= bus.DATA_in[7];
         r_ppn[r_acc_task][w_slot] <= bus.DATA_in[PPN_BITS-1:0];
      end
   end

   // ---------------------------------------------------------------------------
   // Register read mux
   // ---------------------------------------------------------------------------
   logic [7:0] w_rd_data;

   always_comb begin
      w_rd_data = 8'h00;
      case (w_reg_idx)
         4'd0: w_rd_data = {r_fault, 5'b0, r_prot_en, r_en};
         4'd1: w_rd_data = 8'(r_acc_task);
         4'd2: w_rd_data = 8'(r_user_task);
         4'd3: w_rd_data = r_cnt;
         4'd4: w_rd_data = r_flt_adr[15:8];
         4'd5: w_rd_data = r_flt_adr[7:0];
         default: begin
            if (w_slot_ok) begin
               w_rd_data[7]            = r_wp[r_acc_task][w_slot];
               w_rd_data[PPN_BITS-1:0] = r_ppn[r_acc_task][w_slot];
            end
         end
      endcase
   end

   assign bus.DATA_out = w_rd_data;

endmodule

// File: tb/tb_mmu_task.sv
// -----------------------------------------------------------------------------
// tb_mmu_task
// Directed bench for mmu_task with default parameters (4 tasks, 8 KiB pages,
// 7-bit PPN, window at FE20). Inputs change 1 ns after the rising edge of E;
// outputs are sampled a further 1 ns later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_mmu_task;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   mmu_task_if #(.PPN_BITS(7)) bus ();

   mmu_task #(
      .NUM_TASKS (4),
      .PAGE_BITS (13),
      .PPN_BITS  (7),
      .MMU_BASE  (16'hFE20)
   ) dut (
      .E     (clk),
      .RESET (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] act,
                        input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // Advance one E edge and settle just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.ADDR    = 16'h0000;
      bus.RnW     = 1'b1;
      bus.BA      = 1'b1;
      bus.BS      = 1'b0;
      bus.DATA_in = 8'h00;
   endtask

   task automatic bus_wr(input logic [15:0] addr, input logic [7:0] data);
      bus.ADDR    = addr;
      bus.RnW     = 1'b0;
      bus.DATA_in = data;
      tick();
      idle();
   endtask

   task automatic bus_rd(input string tag, input logic [15:0] addr,
                         input logic [7:0] exp);
      bus.ADDR = addr;
      bus.RnW  = 1'b1;
      #1;
      check(tag, 16'(bus.DATA_out), 16'(exp));
      idle();
      #1;
   endtask

   task automatic translate(input string tag, input logic [15:0] addr,
                            input logic [6:0] exp);
      bus.ADDR = addr;
      bus.RnW  = 1'b1;
      #1;
      check(tag, 16'(bus.PPN), 16'(exp));
      idle();
      #1;
   endtask

   task automatic vector_fetch();
      bus.BA = 1'b0;
      bus.BS = 1'b1;
      tick();
      idle();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      idle();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      #1;

      // ---------------- reset state, MMU disabled ----------------
      check("rst_active", 16'(bus.ACTIVE_TASK), 16'h0);
      check("rst_fault", 16'(bus.FAULT), 16'h0);
      translate("rst_ppn_a000", 16'hA000, 7'd5);
      bus.ADDR = 16'hA000;
      bus.RnW  = 1'b0;
      #1;
      check("rst_wrinh", 16'(bus.WR_INHIBIT), 16'h0);
      idle();
      bus_rd("rst_fe28", 16'hFE28, 8'h00);
      bus_rd("rst_fe2d", 16'hFE2D, 8'h05);
      bus_rd("rst_ctrl", 16'hFE20, 8'h00);
      bus_rd("rd_fe26", 16'hFE26, 8'h00);
      bus.ADDR = 16'hFE2F;
      bus.RnW  = 1'b1;
      #1;
      check("sel_fe2f", 16'(bus.MMU_SEL), 16'h1);
      check("oe_fe2f", 16'(bus.DATA_oe), 16'h1);
      bus.ADDR = 16'hFE1F;
      #1;
      check("sel_fe1f", 16'(bus.MMU_SEL), 16'h0);
      idle();

      // ---------------- table write, GO countdown ----------------
      bus_wr(16'hFE21, 8'h01);
      bus_wr(16'hFE2A, 8'h42);
      bus_wr(16'hFE22, 8'h01);
      bus_wr(16'hFE20, 8'h01);
      bus_rd("acctask", 16'hFE21, 8'h01);
      bus_rd("entry_t1p2", 16'hFE2A, 8'h42);
      translate("t0_ppn_4000", 16'h4000, 7'h02);
      bus_wr(16'hFE23, 8'h02);
      bus_rd("go_cnt2", 16'hFE23, 8'h02);
      check("go_edge0", 16'(bus.ACTIVE_TASK), 16'h0);
      tick();
      check("go_edge1", 16'(bus.ACTIVE_TASK), 16'h0);
      tick();
      check("go_edge2", 16'(bus.ACTIVE_TASK), 16'h0);
      tick();
      check("go_edge3", 16'(bus.ACTIVE_TASK), 16'h1);
      translate("t1_ppn_4000", 16'h4000, 7'h42);
      bus_rd("go_done_cnt", 16'hFE23, 8'h00);

      // ---------------- vector fetch overrides an expiring GO ----------------
      bus_wr(16'hFE23, 8'h01);
      tick();
      vector_fetch();
      check("vec_active", 16'(bus.ACTIVE_TASK), 16'h0);
      repeat (2) tick();
      check("vec_pend_clr", 16'(bus.ACTIVE_TASK), 16'h0);
      bus_rd("vec_cnt", 16'hFE23, 8'h00);

      // Back to task 1 with GO=0: switch on the very next edge.
      bus_wr(16'hFE23, 8'h00);
      check("go0_edge0", 16'(bus.ACTIVE_TASK), 16'h0);
      tick();
      check("go0_edge1", 16'(bus.ACTIVE_TASK), 16'h1);

      // ---------------- write protection ----------------
      bus_wr(16'hFE2A, 8'hC2);
      bus_wr(16'hFE20, 8'h03);
      bus.ADDR = 16'h4123;
      bus.RnW  = 1'b0;
      #1;
      check("prot_wrinh", 16'(bus.WR_INHIBIT), 16'h1);
      check("prot_ppn", 16'(bus.PPN), 16'h42);
      check("prot_pre_fault", 16'(bus.FAULT), 16'h0);
      tick();
      idle();
      check("prot_fault", 16'(bus.FAULT), 16'h1);
      bus_rd("fltadr_hi", 16'hFE24, 8'h41);
      bus_rd("fltadr_lo", 16'hFE25, 8'h23);
      bus_rd("ctrl_fault", 16'hFE20, 8'h83);
      bus.ADDR = 16'h5000;
      bus.RnW  = 1'b0;
      #1;
      check("prot2_wrinh", 16'(bus.WR_INHIBIT), 16'h1);
      tick();
      idle();
      bus_rd("fltadr2_hi", 16'hFE24, 8'h41);
      bus_rd("fltadr2_lo", 16'hFE25, 8'h23);
      bus.ADDR = 16'h2000;
      bus.RnW  = 1'b0;
      #1;
      check("unprot_wrinh", 16'(bus.WR_INHIBIT), 16'h0);
      idle();
      bus_wr(16'hFE20, 8'h83);
      check("fault_clr", 16'(bus.FAULT), 16'h0);
      bus_rd("ctrl_after_clr", 16'hFE20, 8'h03);

      // ---------------- system task is never inhibited ----------------
      vector_fetch();
      bus_wr(16'hFE21, 8'h00);
      bus_wr(16'hFE2A, 8'hC2);
      check("sys_active", 16'(bus.ACTIVE_TASK), 16'h0);
      bus.ADDR = 16'h4123;
      bus.RnW  = 1'b0;
      #1;
      check("sys_ppn", 16'(bus.PPN), 16'h42);
      check("sys_wrinh", 16'(bus.WR_INHIBIT), 16'h0);
      tick();
      idle();
      check("sys_fault", 16'(bus.FAULT), 16'h0);

      // ---------------- reset in the middle of a countdown ----------------
      bus_wr(16'hFE22, 8'h01);
      bus_wr(16'hFE23, 8'h05);
      bus_rd("mid_cnt", 16'hFE23, 8'h05);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_active", 16'(bus.ACTIVE_TASK), 16'h0);
      bus_rd("mid_cnt_clr", 16'hFE23, 8'h00);
      bus_rd("mid_fe2a", 16'hFE2A, 8'h02);
      bus_rd("mid_ctrl", 16'hFE20, 8'h00);
      repeat (8) tick();
      check("mid_no_switch", 16'(bus.ACTIVE_TASK), 16'h0);
      translate("mid_ppn_a000", 16'hA000, 7'd5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
